dht11_controller: RTL and testbench
===================================

# dht11_controller

Sequences one complete DHT11 single-wire read transaction: drives the host start pulse, checks the sensor response preamble, measures 40 data bits against a microsecond timebase, and presents humidity and temperature bytes. It sits between the 50 MHz system clock domain and the bidirectional sensor pin, above the microsecond timebase and below the UART/display logic that requests readings. It derives all timing from an internal one-cycle microsecond tick.

## Interface
- CLK_FREQ_HZ, 50_000_000, system clock frequency; CLKS_PER_US = CLK_FREQ_HZ/1_000_000 (50)
- START_LOW_US, 18000, host start pulse width
- TIMEOUT_US, 100, maximum wait in any sensor-driven state
- BIT_THRESH_US, 40, high-time threshold; a high time strictly greater than this is a 1
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- dht_in  in  1  raw sensor pin level, asynchronous
- dht_oe  out  1  1 = drive pin low; 0 = release (pull-up)
- busy  out  1  high from accepted start until done/error
- done  out  1  one-cycle pulse, valid data latched
- error  out  1  sticky; cleared by next accepted start
- hum_int, hum_dec, temp_int, temp_dec  out  8 each  latched data bytes

## Operation
- dht_in passes through a 2-flop synchronizer; edges are detected on the synchronized value.
- A us counter clears on every state entry and increments on each tick, saturating at 16 bits.
- States and transitions:
  - IDLE: dht_oe=0. start -> START_LOW; clear error.
  - START_LOW: dht_oe=1. Counter reaches START_LOW_US -> RELEASE.
  - RELEASE: dht_oe=0. Line low -> RESP_LOW.
  - RESP_LOW: wait for line high -> RESP_HIGH.
  - RESP_HIGH: wait for line low -> BIT_LOW.
  - BIT_LOW: wait for line high -> BIT_HIGH.
  - BIT_HIGH: on falling edge, shift in (count > BIT_THRESH_US) MSB-first. Bit index 39 -> CHECK; otherwise -> BIT_LOW.
  - CHECK: latch the four data bytes, pulse done -> IDLE.
  - ERROR: one cycle that sets error -> IDLE.
- Any sensor-driven state whose counter reaches TIMEOUT_US -> ERROR.
- Byte order on the wire: hum_int, hum_dec, temp_int, temp_dec, checksum.
- Data outputs hold their last good values. They are not modified on error.
- start while busy is ignored. start in the same cycle as reset is ignored.

## Timing
- Reset values: dht_oe=0, busy=0, done=0, error=0, all data bytes 0x00, state IDLE, bit index 0.
- Reset mid-transaction: dht_oe deasserts the next cycle and no done pulse is produced.
- start accepted at cycle N: dht_oe=1 and busy=1 at N+1.
- The start pulse lasts START_LOW_US ticks (900000 clocks, with up to one tick of first-tick jitter).
- Input-to-decision latency: 2 synchronizer cycles plus 1 edge-detect cycle.
- done and the final data bytes update in the same cycle. busy falls in that cycle.
- The tick generator free-runs from reset. It counts 0..CLKS_PER_US-1 and pulses at the terminal count.
- Timeout equal to TIMEOUT_US (count == TIMEOUT_US) takes priority over an edge in the same cycle.

## Configuration
- DHT11_CHECKSUM_EN defined:
  - CHECK compares the received checksum with the 8-bit sum (mod 256) of the four data bytes.
  - On mismatch it goes to ERROR; data is not latched and done does not pulse.
- DHT11_CHECKSUM_EN undefined: the checksum byte is shifted in and discarded, and CHECK always latches and pulses done.

## Structure
- Shared package dht11_pkg holds:
  - the state enum typedef;
  - default timing constants (START_LOW_US, TIMEOUT_US, BIT_THRESH_US);
  - the frame width constant, FRAME_BITS = 40.
- One sub-module, us_tick: parameter CLKS_PER_US; ports clk, reset, tick. It emits a one-cycle pulse per microsecond.
- The synchronizer, FSM, shift register and checksum stay in dht11_controller.

## Test plan
- Sensor model sends 0x37 0x00 0x19 0x00 0x50 -> done pulses once; hum_int=55, temp_int=25, error=0.
- Start pulse width: dht_oe high for 900000±50 clocks, then released.
- Bit threshold: high widths 28 µs -> 0, 70 µs -> 1, 40 µs -> 0, 41 µs -> 1.
- Sensor never responds after release -> error=1 after 100 µs; data unchanged; busy=0.
- Checksum 0x51 with frame above:
  - DHT11_CHECKSUM_EN defined: error=1 and no done.
  - Undefined: done with the same data.
- reset asserted during bit 20 -> next cycle dht_oe=0, busy=0, state IDLE; a subsequent start completes a normal read.

Source files
------------

// File: rtl/dht11_pkg.sv
// Shared types and default timing for the DHT11 single-wire read controller.
package dht11_pkg;

  localparam int START_LOW_US  = 18000;
  localparam int TIMEOUT_US    = 100;
  localparam int BIT_THRESH_US = 40;
  localparam int FRAME_BITS    = 40;
  localparam int DATA_BITS     = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START_LOW,
    ST_RELEASE,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_CHECK,
    ST_ERROR
  } state_t;

  // Sensor checksum: plain 8-bit wrap-around sum of the four data bytes.
  function automatic logic [7:0] frame_sum(input logic [DATA_BITS-1:0] d);
    return d[31:24] + d[23:16] + d[15:8] + d[7:0];
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Free-running microsecond timebase: one-cycle tick every CLKS_PER_US clocks.
module us_tick #(
  parameter int CLKS_PER_US = 50
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_US - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)              cnt_q <= '0;
    else if (cnt_q == TERM) cnt_q <= '0;
    else                    cnt_q <= cnt_q + 1'b1;
  end

  assign tick = (cnt_q == TERM);

endmodule

// File: rtl/dht11_controller.sv
// One complete DHT11 read: start pulse, response preamble, 40 timed bits, latched bytes.
// Define DHT11_CHECKSUM_EN to reject frames whose checksum byte does not match.
module dht11_controller #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int START_LOW_US  = dht11_pkg::START_LOW_US,
  parameter int TIMEOUT_US    = dht11_pkg::TIMEOUT_US,
  parameter int BIT_THRESH_US = dht11_pkg::BIT_THRESH_US
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec
);

  import dht11_pkg::*;

  localparam int          CLKS_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam logic [15:0] START_CNT   = 16'(START_LOW_US);
  localparam logic [15:0] TMO_CNT     = 16'(TIMEOUT_US);
  localparam logic [15:0] THR_CNT     = 16'(BIT_THRESH_US);
  localparam logic [5:0]  LAST_BIT    = 6'(FRAME_BITS - 1);

  logic tick;

  us_tick #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Pin synchronizer plus one history flop for edge detection; idle line is pulled up.
  logic sync1_q, sync2_q, prev_q;
  logic rise, fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= dht_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  state_t               state_q, state_d;
  logic [15:0]          us_q, us_now;
  logic [5:0]           bit_idx_q;
  logic [DATA_BITS-1:0] data_sr_q;
  logic                 timeout, bit_val, csum_ok;
  logic                 accept, shift_en, latch_en, set_err;

  // us_now is the count including this cycle's tick, so a pulse of W us measures exactly W.
  assign us_now  = (tick && (us_q != 16'hFFFF)) ? us_q + 16'd1 : us_q;
  assign timeout = (us_now >= TMO_CNT);
  assign bit_val = (us_now > THR_CNT);

`ifdef DHT11_CHECKSUM_EN
  logic [7:0] csum_sr_q;
  assign csum_ok = (csum_sr_q == frame_sum(data_sr_q));
`else
  assign csum_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (start) state_d = ST_START_LOW;
      ST_START_LOW: if (us_now >= START_CNT) state_d = ST_RELEASE;
      ST_RELEASE:   if (timeout) state_d = ST_ERROR; else if (fall) state_d = ST_RESP_LOW;
      ST_RESP_LOW:  if (timeout) state_d = ST_ERROR; else if (rise) state_d = ST_RESP_HIGH;
      ST_RESP_HIGH: if (timeout) state_d = ST_ERROR; else if (fall) state_d = ST_BIT_LOW;
      ST_BIT_LOW:   if (timeout) state_d = ST_ERROR; else if (rise) state_d = ST_BIT_HIGH;
      ST_BIT_HIGH: begin
        if (timeout)   state_d = ST_ERROR;
        else if (fall) state_d = (bit_idx_q == LAST_BIT) ? ST_CHECK : ST_BIT_LOW;
      end
      ST_CHECK:     state_d = csum_ok ? ST_IDLE : ST_ERROR;
      ST_ERROR:     state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dht_oe   = 1'b0;
    busy     = 1'b1;
    accept   = 1'b0;
    shift_en = 1'b0;
    latch_en = 1'b0;
    set_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy   = 1'b0;
        accept = start;
      end
      ST_START_LOW: dht_oe   = 1'b1;
      ST_BIT_HIGH:  shift_en = fall & ~timeout;
      ST_CHECK:     latch_en = csum_ok;
      ST_ERROR:     set_err  = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                   us_q <= '0;
    else if (state_d != state_q) us_q <= '0;
    else                         us_q <= us_now;
  end

  // The first 32 bits are data; the last 8 are the checksum and never enter data_sr_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx_q <= '0;
      data_sr_q <= '0;
    end else if (accept) begin
      bit_idx_q <= '0;
    end else if (shift_en) begin
      bit_idx_q <= bit_idx_q + 6'd1;
      if (!bit_idx_q[5]) data_sr_q <= {data_sr_q[DATA_BITS-2:0], bit_val};
    end
  end

`ifdef DHT11_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset)                      csum_sr_q <= '0;
    else if (shift_en && bit_idx_q[5]) csum_sr_q <= {csum_sr_q[6:0], bit_val};
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      done     <= 1'b0;
      error    <= 1'b0;
      hum_int  <= '0;
      hum_dec  <= '0;
      temp_int <= '0;
      temp_dec <= '0;
    end else begin
      done <= latch_en;
      if (accept)       error <= 1'b0;
      else if (set_err) error <= 1'b1;
      if (latch_en) {hum_int, hum_dec, temp_int, temp_dec} <= data_sr_q;
    end
  end

endmodule

// File: tb/tb_dht11_controller.sv
// Self-checking bench: a timed sensor model on the pin, a table of frames and corner-case sequences.
module tb_dht11_controller;

  import dht11_pkg::*;

  localparam int CPU       = 2;
  localparam int S_US      = 20;
  localparam int T_US      = 100;
  localparam int THR_US    = 40;
  localparam int PRE_US    = 20;
  localparam int RESP_US   = 80;
  localparam int BIT_LO_US = 12;
  localparam int TAIL_US   = 20;
`ifdef DHT11_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       sensor_low = 1'b0;
  logic       dht_in;
  logic       dht_oe, busy, done, error;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;

  // Open-drain bus: either side can pull low, otherwise the pull-up wins.
  assign dht_in = ~(dht_oe | sensor_low);

  dht11_controller #(
    .CLK_FREQ_HZ   (CPU * 1_000_000),
    .START_LOW_US  (S_US),
    .TIMEOUT_US    (T_US),
    .BIT_THRESH_US (THR_US)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dht_in   (dht_in),
    .dht_oe   (dht_oe),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .hum_int  (hum_int),
    .hum_dec  (hum_dec),
    .temp_int (temp_int),
    .temp_dec (temp_dec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] frame;
    bit          rand_w;
    bit          exp_done;
    logic [31:0] exp_data;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  logic [31:0] done_data = '0;
  logic        done_busy = 1'b0;
  int          hi_us [FRAME_BITS];
  logic [31:0] model_data = '0;
  vec_t        vecs [5];

  always @(posedge clk) begin
    if (done === 1'b1) begin
      done_cnt  <= done_cnt + 1;
      done_data <= {hum_int, hum_dec, temp_int, temp_dec};
      done_busy <= busy;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d expected=[%0d..%0d]", name, act, lo, hi);
    end
  endtask

  task automatic hold(input int us);
    repeat (us * CPU) @(negedge clk);
  endtask

  function automatic bit model_accept(input logic [39:0] rx);
    logic [7:0] s;
    s = rx[39:32] + rx[31:24] + rx[23:16] + rx[15:8];
    return !CSUM_EN || (s == rx[7:0]);
  endfunction

  // What the controller should hear, decided purely from the high-pulse widths on the wire.
  function automatic logic [39:0] model_rx();
    logic [39:0] rx;
    rx = '0;
    for (int i = 0; i < FRAME_BITS; i++) rx[39-i] = (hi_us[i] > THR_US);
    return rx;
  endfunction

  task automatic set_widths(input logic [39:0] frame, input bit rand_w);
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (frame[39-i]) hi_us[i] = rand_w ? int'($urandom_range(75, 41)) : 70;
      else             hi_us[i] = rand_w ? int'($urandom_range(40, 15)) : 28;
    end
  endtask

  // Pulses start, checks acceptance, returns at the first cycle with the pin released.
  task automatic do_start();
    int w;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("accept_oe", dht_oe, 1);
    check("accept_busy", busy, 1);
    check("accept_error_clear", error, 0);
    w = 0;
    while (dht_oe === 1'b1 && w < (S_US + 4) * CPU) begin
      start = (w == 3);
      w++;
      @(negedge clk);
    end
    start = 1'b0;
    check_range("start_low_clks", w, (S_US - 1) * CPU, (S_US + 1) * CPU);
  endtask

  // Full frames end with the tail and release; short frames stop mid-way through the next low.
  task automatic sensor_reply(input int n_bits);
    hold(PRE_US);
    sensor_low = 1'b1;
    hold(RESP_US);
    sensor_low = 1'b0;
    hold(RESP_US);
    for (int i = 0; i < n_bits; i++) begin
      sensor_low = 1'b1;
      hold(BIT_LO_US);
      sensor_low = 1'b0;
      hold(hi_us[i]);
    end
    sensor_low = 1'b1;
    if (n_bits < FRAME_BITS) begin
      hold(BIT_LO_US / 2);
    end else begin
      hold(TAIL_US);
      sensor_low = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input bit exp_done, input logic [31:0] exp_data, input string tag);
    int d0;
    d0 = done_cnt;
    do_start();
    sensor_reply(FRAME_BITS);
    wait_idle(tag);
    check({tag, "_done_count"}, done_cnt - d0, exp_done);
    check({tag, "_error"}, error, !exp_done);
    check({tag, "_data"}, {hum_int, hum_dec, temp_int, temp_dec}, exp_data);
    if (exp_done) begin
      check({tag, "_data_at_done"}, done_data, exp_data);
      check({tag, "_busy_at_done"}, done_busy, 0);
    end
    model_data = exp_data;
  endtask

  initial begin
    logic [39:0] rx;
    logic [31:0] d;
    logic [7:0]  cs;
    bit          acc;
    int          n, d0;

    // Stimulus table; expectations follow the running "last good data" of the model.
    vecs[0] = '{40'h37_00_19_00_50, 1'b0, 1'b1, 32'h37_00_19_00};
    vecs[1] = '{40'h37_00_19_00_51, 1'b0, !CSUM_EN, 32'h37_00_19_00};
    model_data = 32'h37_00_19_00;
    for (int k = 2; k < 5; k++) begin
      d  = $urandom;
      cs = d[31:24] + d[23:16] + d[15:8] + d[7:0];
      if ($urandom_range(2, 0) == 0) cs = cs ^ 8'h01;
      acc = model_accept({d, cs});
      vecs[k] = '{{d, cs}, 1'b1, acc, acc ? d : model_data};
      if (acc) model_data = d;
    end
    model_data = '0;

    repeat (3) @(negedge clk);
    check("rst_dht_oe", dht_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_hum_int", hum_int, 0);
    check("rst_hum_dec", hum_dec, 0);
    check("rst_temp_int", temp_int, 0);
    check("rst_temp_dec", temp_dec, 0);

    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("start_during_reset_busy", busy, 0);
    @(negedge clk);
    check("start_during_reset_oe", dht_oe, 0);
    check("start_during_reset_busy2", busy, 0);

    for (int k = 0; k < 5; k++) begin
      set_widths(vecs[k].frame, vecs[k].rand_w);
      run_frame(vecs[k].exp_done, vecs[k].exp_data, $sformatf("vec%0d", k));
    end
    check("spec_frame_hum_int", vecs[0].exp_data[31:24], 8'd55);

    // Threshold corners on the first four bits: 28, 70, 40, 41 us.
    set_widths(40'h5A_11_22_33_C0, 1'b0);
    hi_us[0] = 28;
    hi_us[1] = 70;
    hi_us[2] = 40;
    hi_us[3] = 41;
    rx = model_rx();
    run_frame(model_accept(rx), model_accept(rx) ? rx[39:8] : model_data, "thresh");
    check("thresh_hum_int", hum_int, 8'h5A);

    // Sensor never answers after release.
    d0 = done_cnt;
    do_start();
    n = 0;
    while (error !== 1'b1 && n < (T_US + 4) * CPU) begin
      @(negedge clk);
      n++;
    end
    check_range("timeout_clks", n, (T_US - 1) * CPU, (T_US + 1) * CPU);
    check("timeout_busy", busy, 0);
    check("timeout_data", {hum_int, hum_dec, temp_int, temp_dec}, model_data);
    check("timeout_no_done", done_cnt - d0, 0);

    // Reset during bit 20, then a clean read.
    d0 = done_cnt;
    set_widths({$urandom, 8'h00}, 1'b1);
    do_start();
    sensor_reply(20);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_oe", dht_oe, 0);
    check("midreset_busy", busy, 0);
    sensor_low = 1'b0;
    hold(5);
    check("midreset_no_done", done_cnt - d0, 0);
    check("midreset_error", error, 0);
    d  = $urandom;
    cs = d[31:24] + d[23:16] + d[15:8] + d[7:0];
    set_widths({d, cs}, 1'b1);
    run_frame(1'b1, d, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
